y86_data_mem: RTL and testbench
===============================

# y86_data_mem

Parametrised, handshaked data memory for the Y86 processor's memory stage. Replaces the fixed twenty-word register bank with a configurable-depth, word-addressed array plus:
- a post-reset clear sequencer;
- registered one-cycle read latency;
- address and operation error reporting;
- a combinational debug read port for benches and waveform inspection.

## Interface
Parameters:
- WIDTH, 64, data word width in bits
- DEPTH, 20, number of words (>= 2)
- BASE, 1, lowest valid address; valid range is BASE .. BASE+DEPTH-1
- AW, 64, address width in bits

Ports:
- clk  in  1  clock, rising edge
- res  in  1  reset, asynchronous, active-high
- req  in  1  request strobe; accepted on a rising edge when ready=1
- read  in  1  read operation for this request
- write  in  1  write operation for this request
- addr  in  AW  word address
- data  in  WIDTH  write data
- ready  out  1  block accepts requests
- done  out  1  one-cycle pulse: response for the request accepted on the previous edge
- valM  out  WIDTH  read data, valid when done=1
- memerr  out  1  error for the current response, valid when done=1
- err_sticky  out  1  set on any memerr; cleared only by res
- dbg_addr  in  AW  debug address
- dbg_data  out  WIDTH  combinational contents at dbg_addr

## Operation
- Storage: DEPTH x WIDTH array. Index = addr - BASE, computed at full AW width.
- In range means BASE <= addr <= BASE+DEPTH-1, compared at full AW width. Upper address bits never alias.
- States:
  - CLEAR:
    - ready=0.
    - Counter clr_idx writes zero to entry clr_idx on each edge and increments.
    - After writing entry DEPTH-1, go to RUN.
  - RUN:
    - ready=1.
    - Stays in RUN until res.
- Request decode, on an accepting edge (req=1 and ready=1), by priority:
  - read=1 and write=1: memerr=1, no write, valM=0.
  - Address out of range, with read or write set: memerr=1, no write, valM=0.
  - write=1: array[index] <= data; valM=0, memerr=0.
  - read=1: valM <= array[index], memerr=0.
  - Neither set: nop. done=1, valM=0, memerr=0.
- Requests with ready=0 are ignored: no write, no done, no error.
- done is driven every cycle. It is 1 exactly on the cycle after an accepting edge, otherwise 0.
- valM and memerr hold their last value when done=0.
- err_sticky <= err_sticky | (accepting edge and error condition).
- dbg_data:
  - array[dbg_addr-BASE] if dbg_addr is in range, else 0.
  - Reflects partial clear during CLEAR.
  - Has no effect on the request path.

## Timing
- Reset values, all forced asynchronously while res=1:
  - state=CLEAR, clr_idx=0;
  - ready=0, done=0, valM=0, memerr=0, err_sticky=0.
  - Array contents are undefined until cleared.
- Clear sequence:
  - After res falls, DEPTH rising edges clear entries 0..DEPTH-1.
  - ready=1 immediately after the DEPTH-th edge.
  - The first request can be accepted on edge DEPTH+1.
- Latency:
  - Request presented in cycle N and accepted at the end-of-N edge.
  - done, valM and memerr are valid in cycle N+1.
  - Throughput is one request per cycle.
- Back-to-back: a write to A accepted at edge k followed by a read of A accepted at edge k+1 returns the new data in cycle k+2.
- res asserted mid-CLEAR or mid-RUN: immediate return to reset values.
  - The clear restarts from index 0 after res falls.
  - An in-flight response is discarded: done=0.
- Array writes occur only on accepting edges in RUN or clear edges in CLEAR. Both never happen on the same edge.

## Test plan
- Reset release with DEPTH=20, BASE=1:
  - ready=0 for 20 edges, then 1.
  - dbg_data at addresses 1..20 all read 0.
  - done=0 throughout.
- Write then read:
  - Write 0xDEADBEEF_00000007 to addr 7; next cycle read addr 7.
  - Write response: done=1, memerr=0.
  - Read response, one cycle later: valM=0xDEADBEEF_00000007.
  - Addresses 6 and 8 still read 0.
- Boundaries:
  - Write addr 1 = 0x11 and addr 20 = 0x22: both read back correctly.
  - Write addr 0, 21 and 0x1_0000_0001: each gives memerr=1, err_sticky=1, and dbg_data unchanged everywhere.
- Illegal op:
  - read=1, write=1 at addr 5 with data 0xFF: memerr=1, valM=0, addr 5 still holds 0.
  - nop request: done=1, memerr=0.
- Gating and reset:
  - req=1 during CLEAR: no done.
  - Assert res on clear edge 10: ready=0, and a full 20-edge clear restarts.
  - err_sticky returns to 0.
- Parameter sweep:
  - DEPTH=4, BASE=0x100, WIDTH=32.
  - Clear takes 4 edges.
  - Addresses 0x100..0x103 are valid; 0xFF and 0x104 give memerr=1.

Source files
------------

// File: rtl/y86_data_mem.sv
// y86_data_mem: handshaked, word-addressed data memory for the Y86 memory stage.
// Self-clears after reset, then serves one request per cycle with a registered response.
module y86_data_mem #(
    parameter int unsigned     WIDTH = 64,
    parameter int unsigned     DEPTH = 20,
    parameter longint unsigned BASE  = 1,
    parameter int unsigned     AW    = 64
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req,
    input  logic             read,
    input  logic             write,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] valM,
    output logic             memerr,
    output logic             err_sticky,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int unsigned   CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LO   = AW'(BASE);
    localparam logic [AW-1:0] HI   = AW'(BASE) + AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    clr_q, clr_d;
    logic             clr_we, wr_we;
    logic             ready_q, done_q, memerr_q, err_sticky_q;
    logic [WIDTH-1:0] valm_q;

    logic             in_range, dbg_in_range, accept, op_err;
    logic [CW-1:0]    idx, dbg_idx;

    // Range checks are done at full address width so high bits never alias.
    assign in_range     = (addr >= LO) && (addr <= HI);
    assign idx          = CW'(addr - LO);
    assign dbg_in_range = (dbg_addr >= LO) && (dbg_addr <= HI);
    assign dbg_idx      = CW'(dbg_addr - LO);

    assign accept = req & ready_q;
    assign op_err = (read & write) | ((read | write) & ~in_range);

    // State and clear-counter registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Next state, clear sequencing and array write enables.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        clr_we  = 1'b0;
        wr_we   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                clr_d  = clr_q + CW'(1);
                if (clr_q == LAST) begin
                    state_d = S_RUN;
                    clr_d   = '0;
                end
            end
            S_RUN: begin
                wr_we = accept & write & ~op_err;
            end
            default: begin
                state_d = S_CLEAR;
                clr_d   = '0;
            end
        endcase
    end

    // Storage carries no reset; contents are defined only once the clear has swept them.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_q] <= '0;
        end else if (wr_we) begin
            mem[idx] <= data;
        end
    end

    // Registered handshake and response; valM/memerr hold between responses.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            memerr_q     <= 1'b0;
            valm_q       <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            ready_q      <= (state_d == S_RUN);
            done_q       <= accept;
            err_sticky_q <= err_sticky_q | (accept & op_err);
            if (accept) begin
                memerr_q <= op_err;
                valm_q   <= (read & ~op_err) ? mem[idx] : '0;
            end
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign valM       = valm_q;
    assign memerr     = memerr_q;
    assign err_sticky = err_sticky_q;
    assign dbg_data   = dbg_in_range ? mem[dbg_idx] : '0;

endmodule

// File: tb/tb_y86_data_mem.sv
// Bench for y86_data_mem: default 20x64 instance driven from a vector table with a
// response scoreboard, plus a 4x32 instance at BASE 0x100 for the parameter sweep.
module tb_y86_data_mem;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] a;
        logic [63:0] d;
        logic        err;
        logic [63:0] val;
    } vec_t;

    typedef struct {
        logic        err;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res, req, read, write;
    logic [63:0] addr, data, dbg_addr;
    logic        ready, done, memerr, err_sticky;
    logic [63:0] valm, dbg_data;

    logic        res_b, req_b, read_b, write_b;
    logic [63:0] addr_b, dbg_addr_b;
    logic [31:0] data_b, valm_b, dbg_data_b;
    logic        ready_b, done_b, memerr_b, err_sticky_b;

    y86_data_mem dut (
        .clk(clk), .res(res), .req(req), .read(read), .write(write),
        .addr(addr), .data(data), .ready(ready), .done(done), .valM(valm),
        .memerr(memerr), .err_sticky(err_sticky), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    y86_data_mem #(.WIDTH(32), .DEPTH(4), .BASE(64'h100), .AW(64)) dut_b (
        .clk(clk), .res(res_b), .req(req_b), .read(read_b), .write(write_b),
        .addr(addr_b), .data(data_b), .ready(ready_b), .done(done_b), .valM(valm_b),
        .memerr(memerr_b), .err_sticky(err_sticky_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
    );

    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [63:0] model [1:20];
    vec_t        vecs [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One edge on instance A; any queued expectation must be answered right after it.
    task automatic step_a();
        exp_t e;
        logic want;
        want = (sb.size() != 0);
        @(posedge clk);
        #1;
        chk("done", 64'(done), 64'(want));
        if (want) begin
            e = sb.pop_front();
            chk("memerr", 64'(memerr), 64'(e.err));
            chk("valM", valm, e.val);
        end
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        req   = 1'b1;
        read  = v.rd;
        write = v.wr;
        addr  = v.a;
        data  = v.d;
        e.err = v.err;
        e.val = v.val;
        sb.push_back(e);
        step_a();
        req   = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        if (v.wr && !v.rd && !v.err) model[int'(v.a)] = v.d;
    endtask

    // Caller drops res just after an edge; checks the 20-edge clear on instance A.
    task automatic clear_a();
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            chk("ready_clr", 64'(ready), 64'(i == 20));
            chk("done_clr", 64'(done), 64'd0);
        end
    endtask

    task automatic check_dbg();
        logic [63:0] a;
        logic [63:0] exp;
        for (int i = 0; i <= 23; i++) begin
            a = (i == 22) ? 64'h1_0000_0001 : (i == 23) ? 64'h1_0000_0014 : 64'(i);
            dbg_addr = a;
            #1;
            exp = (i >= 1 && i <= 20) ? model[i] : 64'd0;
            chk("dbg_data", dbg_data, exp);
        end
    endtask

    task automatic issue_b(input logic rd, input logic wr, input logic [63:0] a,
                           input logic [31:0] d, input logic err, input logic [31:0] val);
        req_b   = 1'b1;
        read_b  = rd;
        write_b = wr;
        addr_b  = a;
        data_b  = d;
        @(posedge clk);
        #1;
        req_b   = 1'b0;
        read_b  = 1'b0;
        write_b = 1'b0;
        chk("b_done", 64'(done_b), 64'd1);
        chk("b_memerr", 64'(memerr_b), 64'(err));
        chk("b_valM", 64'(valm_b), 64'(val));
    endtask

    initial begin
        res = 1'b1; req = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; data = '0; dbg_addr = '0;
        res_b = 1'b1; req_b = 1'b0; read_b = 1'b0; write_b = 1'b0;
        addr_b = '0; data_b = '0; dbg_addr_b = '0;
        for (int i = 1; i <= 20; i++) model[i] = 64'd0;

        vecs[0]  = '{1'b0, 1'b1, 64'd7,           64'hDEADBEEF_00000007, 1'b0, 64'd0};
        vecs[1]  = '{1'b1, 1'b0, 64'd7,           64'd0,                 1'b0, 64'hDEADBEEF_00000007};
        vecs[2]  = '{1'b1, 1'b0, 64'd6,           64'd0,                 1'b0, 64'd0};
        vecs[3]  = '{1'b1, 1'b0, 64'd8,           64'd0,                 1'b0, 64'd0};
        vecs[4]  = '{1'b0, 1'b1, 64'd1,           64'h11,                1'b0, 64'd0};
        vecs[5]  = '{1'b0, 1'b1, 64'd20,          64'h22,                1'b0, 64'd0};
        vecs[6]  = '{1'b1, 1'b0, 64'd1,           64'd0,                 1'b0, 64'h11};
        vecs[7]  = '{1'b1, 1'b0, 64'd20,          64'd0,                 1'b0, 64'h22};
        vecs[8]  = '{1'b0, 1'b1, 64'd0,           64'h55,                1'b1, 64'd0};
        vecs[9]  = '{1'b0, 1'b1, 64'd21,          64'h66,                1'b1, 64'd0};
        vecs[10] = '{1'b0, 1'b1, 64'h1_0000_0001, 64'h77,                1'b1, 64'd0};
        vecs[11] = '{1'b1, 1'b0, 64'd0,           64'd0,                 1'b1, 64'd0};
        vecs[12] = '{1'b1, 1'b1, 64'd5,           64'hFF,                1'b1, 64'd0};
        vecs[13] = '{1'b1, 1'b0, 64'd5,           64'd0,                 1'b0, 64'd0};
        vecs[14] = '{1'b0, 1'b0, 64'd5,           64'hAA,                1'b0, 64'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valM", valm, 64'd0);
        chk("rst_memerr", 64'(memerr), 64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);

        // A request held during the clear must be ignored.
        req = 1'b1; read = 1'b1; addr = 64'd7;
        res = 1'b0;
        clear_a();
        req = 1'b0; read = 1'b0;
        check_dbg();
        chk("sticky_pre", 64'(err_sticky), 64'd0);

        for (int i = 0; i < 15; i++) issue(vecs[i]);
        chk("sticky_post", 64'(err_sticky), 64'd1);
        check_dbg();

        // Response registers hold once done drops.
        issue(vecs[1]);
        step_a();
        chk("hold_valM", valm, 64'hDEADBEEF_00000007);
        chk("hold_memerr", 64'(memerr), 64'd0);

        // Reset during an in-flight response discards it.
        req = 1'b1; read = 1'b1; addr = 64'd7;
        @(posedge clk);
        #1;
        chk("inflight_done", 64'(done), 64'd1);
        req = 1'b0; read = 1'b0;
        res = 1'b1;
        #1;
        chk("rr_done", 64'(done), 64'd0);
        chk("rr_ready", 64'(ready), 64'd0);
        chk("rr_valM", valm, 64'd0);
        chk("rr_sticky", 64'(err_sticky), 64'd0);

        // Reset again on clear edge 10; the full clear must restart.
        @(posedge clk);
        #1;
        res = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            chk("part_ready", 64'(ready), 64'd0);
        end
        res = 1'b1;
        #1;
        chk("mid_ready", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        res = 1'b0;
        clear_a();
        for (int i = 1; i <= 20; i++) model[i] = 64'd0;
        check_dbg();
        chk("sticky_clr", 64'(err_sticky), 64'd0);

        // 4-deep, 32-bit instance at base 0x100.
        res_b = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk("b_ready_clr", 64'(ready_b), 64'(i == 4));
        end
        issue_b(1'b0, 1'b1, 64'h100, 32'hA5A5A5A5, 1'b0, 32'h0);
        issue_b(1'b0, 1'b1, 64'h103, 32'h12345678, 1'b0, 32'h0);
        issue_b(1'b1, 1'b0, 64'h100, 32'h0,        1'b0, 32'hA5A5A5A5);
        issue_b(1'b1, 1'b0, 64'h103, 32'h0,        1'b0, 32'h12345678);
        issue_b(1'b1, 1'b0, 64'h101, 32'h0,        1'b0, 32'h0);
        chk("b_sticky_pre", 64'(err_sticky_b), 64'd0);
        issue_b(1'b1, 1'b0, 64'hFF,  32'h0,        1'b1, 32'h0);
        issue_b(1'b0, 1'b1, 64'h104, 32'h9,        1'b1, 32'h0);
        chk("b_sticky", 64'(err_sticky_b), 64'd1);
        dbg_addr_b = 64'h103;
        #1;
        chk("b_dbg103", 64'(dbg_data_b), 64'h12345678);
        dbg_addr_b = 64'h104;
        #1;
        chk("b_dbg104", 64'(dbg_data_b), 64'd0);
        dbg_addr_b = 64'h100;
        #1;
        chk("b_dbg100", 64'(dbg_data_b), 64'hA5A5A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
